flit_packetizer: RTL and testbench

//  Transmit side of the VC buffer flit interface: turns a packet descriptor plus a payload word

---
 rtl/flit_packetizer.sv | 88 ++++++++
 tb/tb_flit_packetizer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_packetizer.sv
// flit_packetizer: turns a packet descriptor plus payload words into HEAD/BODY*/TAIL flits
// Ports:
//   clk, arst                     clock; synchronous active-low reset
//   pkt_valid_i/pkt_ready_o       descriptor handshake carrying pkt_len_i/dst/hdr/vc
//   data_valid_i/data_ready_o     payload word handshake carrying data_i
//   fdata_o/valid_o/ready_i       34-bit flit link, one-deep output register
//   vc_id_o                       VC of the flit on fdata_o
//   busy_o                        packet in progress or flit still pending
//   err_len_o                     pulse after an oversize length was accepted (saturated)
module flit_packetizer #(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 8,
    parameter int MAX_LEN = 255
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              pkt_valid_i,
    output logic              pkt_ready_o,
    input  logic [LEN_W-1:0]  pkt_len_i,
    input  logic [5:0]        pkt_dst_i,
    input  logic [15:0]       pkt_hdr_i,
    input  logic [1:0]        pkt_vc_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W+1:0] fdata_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [1:0]        vc_id_o,
    output logic              busy_o,
    output logic              err_len_o
);
    // HEAD state is merged into IDLE: the head only loads when the output slot is free
    typedef enum logic {IDLE, PAYLOAD} state_t;
    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b11;
    state_t            state_q;
    logic [LEN_W-1:0]  rem_q;
    logic [LEN_W-1:0]  len_d;
    logic [DATA_W+1:0] fdata_q;
    logic [1:0]        vc_q;
    logic              valid_q;
    logic              err_q;
    logic              load_ok;
    logic              over_d;
    logic              pkt_acc;
    logic              data_acc;
    assign load_ok      = !valid_q || ready_i;
    // reset also blocks the handshakes in the cycle it is asserted
    assign pkt_ready_o  = arst && state_q == IDLE && load_ok;
    assign data_ready_o = arst && state_q == PAYLOAD && load_ok;
    assign pkt_acc      = pkt_valid_i && pkt_ready_o;
    assign data_acc     = data_valid_i && data_ready_o;
    assign over_d       = int'(pkt_len_i) > MAX_LEN;
    assign len_d        = over_d ? LEN_W'(MAX_LEN) : pkt_len_i;
    assign fdata_o      = fdata_q;
    assign valid_o      = valid_q;
    assign vc_id_o      = vc_q;
    assign busy_o       = state_q != IDLE || valid_q;
    assign err_len_o    = err_q;
    always_ff @(posedge clk) begin
        if (!arst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            fdata_q <= '0;
            vc_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= pkt_acc && over_d;
            if (pkt_acc) begin
                fdata_q <= {T_HEAD, 2'b00, len_d, pkt_dst_i, pkt_hdr_i};
                vc_q    <= pkt_vc_i;
                valid_q <= 1'b1;
                rem_q   <= len_d;
                state_q <= len_d == '0 ? IDLE : PAYLOAD;
            end else if (data_acc) begin
                fdata_q <= {rem_q == LEN_W'(1) ? T_TAIL : T_BODY, data_i};
                valid_q <= 1'b1;
                rem_q   <= rem_q - LEN_W'(1);
                state_q <= rem_q == LEN_W'(1) ? IDLE : PAYLOAD;
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_flit_packetizer.sv
// tb_flit_packetizer: scoreboard bench for flit_packetizer with a packet-level reference model
module tb_flit_packetizer;
    localparam int MAXL = 12;
    localparam int LIM  = 3000;
    typedef struct {
        logic [7:0]  len;
        logic [5:0]  dst;
        logic [15:0] hdr;
        logic [1:0]  vc;
    } desc_t;
    logic        clk = 1'b0;
    logic        arst = 1'b0;
    logic        pkt_valid_i;
    logic        pkt_ready_o;
    logic [7:0]  pkt_len_i;
    logic [5:0]  pkt_dst_i;
    logic [15:0] pkt_hdr_i;
    logic [1:0]  pkt_vc_i;
    logic        data_valid_i;
    logic        data_ready_o;
    logic [31:0] data_i;
    logic [33:0] fdata_o;
    logic        valid_o;
    logic        ready_i;
    logic [1:0]  vc_id_o;
    logic        busy_o;
    logic        err_len_o;
    flit_packetizer #(.DATA_W(32), .LEN_W(8), .MAX_LEN(MAXL)) dut (
        .clk(clk), .arst(arst),
        .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o), .pkt_len_i(pkt_len_i),
        .pkt_dst_i(pkt_dst_i), .pkt_hdr_i(pkt_hdr_i), .pkt_vc_i(pkt_vc_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
        .fdata_o(fdata_o), .valid_o(valid_o), .ready_i(ready_i), .vc_id_o(vc_id_o),
        .busy_o(busy_o), .err_len_o(err_len_o)
    );
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int tests = 0;
    int fails = 0;
    logic [35:0] exp_q[$];
    logic [31:0] wq[$];
    desc_t       dq[$];
    int          tq[$];
    int          hq[$];
    bit          rq[$];
    bit          rmode = 0;
    bit          gap = 0;
    int          xfers = 0;
    int          got_err = 0;
    int          exp_err = 0;
    bit          dr_seen = 0;
    logic [33:0] last_flit = '0;
    task automatic chk(string nm, logic [39:0] act, logic [39:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    // reference model: a packet is a head carrying the saturated count, then that many words,
    // the last one tagged TAIL
    task automatic gen(int len, logic [5:0] dst, logic [15:0] hdr, logic [1:0] vc);
        int n;
        logic [7:0] n8;
        logic [31:0] w;
        desc_t d;
        n = len > MAXL ? MAXL : len;
        n8 = 8'(n);
        if (len > MAXL) exp_err++;
        d.len = 8'(len);
        d.dst = dst;
        d.hdr = hdr;
        d.vc = vc;
        exp_q.push_back({vc, 2'b00, 2'b00, n8, dst, hdr});
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            wq.push_back(w);
            exp_q.push_back({vc, (i == n - 1) ? 2'b11 : 2'b01, w});
        end
        dq.push_back(d);
    endtask
    task automatic drain(string nm);
        int n = 0;
        while ((exp_q.size() > 0 || dq.size() > 0 || wq.size() > 0 || pkt_valid_i || data_valid_i)
               && n < LIM) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(nm, 40'(n < LIM), 40'd1);
        repeat (2) @(negedge clk);
        #1;
    endtask
    bit took_d;
    initial begin
        pkt_valid_i = 0; pkt_len_i = 0; pkt_dst_i = 0; pkt_hdr_i = 0; pkt_vc_i = 0;
        forever begin
            @(negedge clk);
            took_d = arst && pkt_valid_i && pkt_ready_o;
            if (took_d) begin
                dq.delete(0);
                hq.push_back(cyc);
            end
            @(posedge clk);
            #1;
            if (took_d) pkt_valid_i = 0;
            if (!pkt_valid_i && dq.size() > 0 && (!gap || $urandom_range(0, 1) == 1)) begin
                pkt_valid_i = 1;
                pkt_len_i = dq[0].len;
                pkt_dst_i = dq[0].dst;
                pkt_hdr_i = dq[0].hdr;
                pkt_vc_i = dq[0].vc;
            end
        end
    end
    bit took_w;
    initial begin
        data_valid_i = 0; data_i = 0;
        forever begin
            @(negedge clk);
            took_w = arst && data_valid_i && data_ready_o;
            if (took_w) wq.delete(0);
            @(posedge clk);
            #1;
            if (took_w) data_valid_i = 0;
            if (!data_valid_i && wq.size() > 0 && (!gap || $urandom_range(0, 1) == 1)) begin
                data_valid_i = 1;
                data_i = wq[0];
            end
        end
    end
    initial begin
        ready_i = 1;
        forever begin
            @(posedge clk);
            #1;
            if (rq.size() > 0) ready_i = rq.pop_front();
            else ready_i = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end
    bit          stall_q = 0;
    logic [35:0] held_q;
    logic [35:0] e;
    always @(negedge clk) begin
        if (stall_q) chk("stall_hold", {3'b0, valid_o, vc_id_o, fdata_o}, {3'b0, 1'b1, held_q});
        if (arst === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
            xfers++;
            tq.push_back(cyc);
            last_flit = fdata_o;
            if (exp_q.size() == 0) begin
                chk("unexpected_flit", {4'b0, vc_id_o, fdata_o}, 40'hF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("flit", {4'b0, vc_id_o, fdata_o}, {4'b0, e});
            end
        end
        if (arst === 1'b1 && err_len_o === 1'b1) got_err++;
        if (data_ready_o === 1'b1) dr_seen = 1;
        stall_q = arst === 1'b1 && valid_o === 1'b1 && ready_i === 1'b0;
        held_q = {vc_id_o, fdata_o};
    end
    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
    int x0;
    int n;
    initial begin
        // 1: reset held with a descriptor pending
        gen(0, 6'h11, 16'h0F0F, 2'd1);
        repeat (3) begin
            @(negedge clk);
            chk("rst_valid", 40'(valid_o), 40'd0);
            chk("rst_pkt_ready", 40'(pkt_ready_o), 40'd0);
            chk("rst_fdata", 40'(fdata_o), 40'd0);
            chk("rst_busy", 40'(busy_o), 40'd0);
        end
        @(posedge clk);
        #1 arst = 1;
        @(negedge clk);
        chk("rel_pkt_ready", 40'(pkt_ready_o), 40'd1);
        drain("t1_drain");
        // 2: fixed two-word packet; head [29:22]=2, dst 5 -> 0x0085BEEF
        tq.delete();
        dq.push_back('{len: 8'd2, dst: 6'h05, hdr: 16'hBEEF, vc: 2'd2});
        wq.push_back(32'hA5A5A5A5);
        wq.push_back(32'h5A5A5A5A);
        exp_q.push_back({2'd2, 34'h0_0085BEEF});
        exp_q.push_back({2'd2, 34'h1_A5A5A5A5});
        exp_q.push_back({2'd2, 34'h3_5A5A5A5A});
        drain("t2_drain");
        chk("t2_count", 40'(tq.size()), 40'd3);
        if (tq.size() == 3) chk("t2_consec", 40'(tq[2] - tq[0]), 40'd2);
        // 3: single-flit packet never opens the payload port
        dr_seen = 0;
        dq.push_back('{len: 8'd0, dst: 6'h01, hdr: 16'h0000, vc: 2'd1});
        exp_q.push_back({2'd1, 34'h0_00010000});
        drain("t3_drain");
        chk("t3_no_data_ready", 40'(dr_seen), 40'd0);
        chk("t3_idle", 40'(busy_o), 40'd0);
        // 4: stalls while a len=3 packet drains
        x0 = xfers;
        rq = '{1, 0, 0, 1, 0, 1, 1};
        gen(3, 6'h3F, 16'h1357, 2'd3);
        drain("t4_drain");
        chk("t4_count", 40'(xfers - x0), 40'd4);
        chk("t4_tail_type", 40'(last_flit[33:32]), 40'd3);
        // 5: back-to-back single-word packets without bubbles
        tq.delete();
        hq.delete();
        gen(1, 6'h0A, 16'h1111, 2'd0);
        gen(1, 6'h0B, 16'h2222, 2'd1);
        drain("t5_drain");
        chk("t5_count", 40'(tq.size()), 40'd4);
        chk("t5_hs", 40'(hq.size()), 40'd2);
        if (tq.size() == 4 && hq.size() == 2) begin
            chk("t5_latency", 40'(tq[0] - hq[0]), 40'd1);
            chk("t5_consec", 40'(tq[3] - tq[0]), 40'd3);
            chk("t5_hs_on_tail", 40'(hq[1] - tq[1]), 40'd0);
        end
        // saturation of an oversize length
        x0 = xfers;
        gen(200, 6'h22, 16'hCAFE, 2'd2);
        drain("sat_drain");
        chk("sat_count", 40'(xfers - x0), 40'(MAXL + 1));
        chk("sat_err", 40'(got_err), 40'(exp_err));
        // 6: reset after the head transfers drops the tail
        x0 = xfers;
        gen(1, 6'h2A, 16'h1234, 2'd3);
        n = 0;
        while (xfers == x0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t6_head_seen", 40'(xfers - x0), 40'd1);
        @(posedge clk);
        #1 arst = 0;
        @(negedge clk);
        chk("t6_tail_loaded", 40'(valid_o), 40'd1);
        @(negedge clk);
        chk("t6_valid_rst", 40'(valid_o), 40'd0);
        chk("t6_busy_rst", 40'(busy_o), 40'd0);
        @(posedge clk);
        #1 arst = 1;
        exp_q.delete();
        gen(0, 6'h07, 16'hABCD, 2'd2);
        drain("t6_drain");
        // random traffic with stalls and gaps
        rmode = 1;
        gap = 1;
        for (int p = 0; p < 40; p++) begin
            gen(($urandom_range(0, 7) == 0) ? int'($urandom_range(MAXL + 1, 255))
                                            : int'($urandom_range(0, MAXL)),
                6'($urandom), 16'($urandom), 2'($urandom));
        end
        drain("rand_drain");
        chk("rand_err", 40'(got_err), 40'(exp_err));
        chk("rand_idle", 40'(busy_o), 40'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
